// File: rtl/psum_drain_quant_if.sv
// Handshake buses of the psum drain: psum row vectors in, quantized bytes out.
// The slave modport is the drain's view; master is the core/AXI-side view.
interface psum_drain_quant_if #(
  parameter int PSUM_BW   = 32,
  parameter int NUM_COLS  = 32,
  parameter int OUT_BW    = 8,
  parameter int ADDR_PSUM = 11,
  parameter int ADDR_OUT  = 20
);
  logic                        psum_valid;
  logic                        psum_ready;
  logic [PSUM_BW*NUM_COLS-1:0] psum_rows;
  logic [ADDR_PSUM-1:0]        psum_addr;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_BW-1:0]           out_data;
  logic [ADDR_OUT-1:0]         out_addr;
  logic [ADDR_PSUM-1:0]        out_tag;
  logic                        out_last;

  modport slave (
    input  psum_valid, psum_rows, psum_addr, out_ready,
    output psum_ready, out_valid, out_data, out_addr, out_tag, out_last
  );

  modport master (
    output psum_valid, psum_rows, psum_addr, out_ready,
    input  psum_ready, out_valid, out_data, out_addr, out_tag, out_last
  );
endinterface

// File: rtl/psum_drain_quant.sv
// Output drain for the dense core: buffers two psum vectors, serializes lanes,
// requantizes each to int8 in a 3-stage pipe and streams bytes with addresses.
module psum_drain_quant #(
  parameter int PSUM_BW   = 32,
  parameter int NUM_COLS  = 32,
  parameter int OUT_BW    = 8,
  parameter int ADDR_PSUM = 11,
  parameter int ADDR_OUT  = 20
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [5:0]          row_count,
  input  logic [15:0]         quant_mult,
  input  logic [4:0]          quant_shift,
  input  logic signed [7:0]   zero_point,
  input  logic                relu_en,
  input  logic [ADDR_OUT-1:0] out_base_addr,
  input  logic [ADDR_OUT-1:0] row_stride,
  psum_drain_quant_if.slave   bus,
  output logic                busy,
  output logic                done
);
  localparam int PROD_W = PSUM_BW + 17;
  localparam int SUM_W  = PROD_W + 1;
  localparam int LANE_W = $clog2(NUM_COLS);
  localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(NUM_COLS - 1);
  localparam logic signed [SUM_W-1:0] OUT_MAX   = SUM_W'((1 <<< (OUT_BW - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN   = ~OUT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Round-half-up arithmetic right shift of the full-width product.
  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p, input logic [4:0] sh);
    logic signed [PROD_W-1:0] bias;
    bias = (sh == 5'd0) ? '0 : (PROD_W'(1) <<< (sh - 5'd1));
    return (p + bias) >>> sh;
  endfunction

  // Optional ReLU, zero-point offset and saturation to the output byte range.
  function automatic logic signed [OUT_BW-1:0] relu_zp_sat(
    input logic signed [PROD_W-1:0] r, input logic relu, input logic signed [7:0] zp);
    logic signed [SUM_W-1:0]  v;
    logic signed [OUT_BW-1:0] res;
    if (relu && r[PROD_W-1]) v = SUM_W'(zp);
    else                     v = SUM_W'(r) + SUM_W'(zp);
    if (v > OUT_MAX)      res = OUT_BW'(OUT_MAX);
    else if (v < OUT_MIN) res = OUT_BW'(OUT_MIN);
    else                  res = v[OUT_BW-1:0];
    return res;
  endfunction

  state_t state_q, state_d;
  logic [5:0]  rows_q, rows_d, accepted_q, accepted_d, rows_out_q, rows_out_d;
  logic [15:0] mult_q, mult_d;
  logic [4:0]  shift_q, shift_d;
  logic signed [7:0] zp_q, zp_d;
  logic relu_q, relu_d;
  logic [ADDR_OUT-1:0] stride_q, stride_d, addr_q, addr_d, row_base_q, row_base_d;
  logic [PSUM_BW*NUM_COLS-1:0] mem_q [2], mem_d [2];
  logic [ADDR_PSUM-1:0] tag_mem_q [2], tag_mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic psum_ready_q, psum_ready_d, busy_q, busy_d, done_q, done_d;
  logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic signed [PROD_W-1:0] prod_p0_q, prod_p0_d, rnd_p1_q, rnd_p1_d;
  logic signed [OUT_BW-1:0] data_p2_q, data_p2_d;
  logic [ADDR_OUT-1:0]  addr_p0_q, addr_p0_d, addr_p1_q, addr_p1_d, addr_p2_q, addr_p2_d;
  logic [ADDR_PSUM-1:0] tag_p0_q, tag_p0_d, tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
  logic last_p0_q, last_p0_d, last_p1_q, last_p1_d, last_p2_q, last_p2_d;
  logic signed [PSUM_BW-1:0] lane_val;
  logic signed [16:0] mult_s;
  logic adv, issue, pop, push, out_hs, final_hs;

  // The whole pipe freezes while the output byte waits for its handshake.
  assign adv      = !(vld_p2_q && !bus.out_ready);
  assign issue    = (state_q == S_RUN) && (cnt_q != 2'd0) && adv;
  assign pop      = issue && (lane_q == LAST_LANE);
  assign push     = bus.psum_valid && psum_ready_q;
  assign out_hs   = vld_p2_q && bus.out_ready;
  assign final_hs = out_hs && last_p2_q && (rows_out_q == rows_q - 6'd1);
  assign lane_val = mem_q[rd_ptr_q][int'(lane_q)*PSUM_BW +: PSUM_BW];
  assign mult_s   = {1'b0, mult_q};

  // Next-state logic for FSM, FIFO, lane/address counters and pipeline.
  always_comb begin
    state_d = state_q;  rows_d = rows_q;  accepted_d = accepted_q;  rows_out_d = rows_out_q;
    mult_d = mult_q;  shift_d = shift_q;  zp_d = zp_q;  relu_d = relu_q;  stride_d = stride_q;
    addr_d = addr_q;  row_base_d = row_base_q;  lane_d = lane_q;
    mem_d = mem_q;  tag_mem_d = tag_mem_q;  wr_ptr_d = wr_ptr_q;  rd_ptr_d = rd_ptr_q;  cnt_d = cnt_q;
    vld_p0_d = vld_p0_q;  vld_p1_d = vld_p1_q;  vld_p2_d = vld_p2_q;
    prod_p0_d = prod_p0_q;  addr_p0_d = addr_p0_q;  tag_p0_d = tag_p0_q;  last_p0_d = last_p0_q;
    rnd_p1_d = rnd_p1_q;  addr_p1_d = addr_p1_q;  tag_p1_d = tag_p1_q;  last_p1_d = last_p1_q;
    data_p2_d = data_p2_q;  addr_p2_d = addr_p2_q;  tag_p2_d = tag_p2_q;  last_p2_d = last_p2_q;

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;  rows_d = row_count;  mult_d = quant_mult;  shift_d = quant_shift;
        zp_d = zero_point;  relu_d = relu_en;  stride_d = row_stride;
        addr_d = out_base_addr;  row_base_d = out_base_addr;
        accepted_d = 6'd0;  rows_out_d = 6'd0;  lane_d = '0;
      end
      S_RUN:  if (rows_q == 6'd0 || final_hs) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q]     = bus.psum_rows;
      tag_mem_d[wr_ptr_q] = bus.psum_addr;
      wr_ptr_d            = ~wr_ptr_q;
      accepted_d          = accepted_q + 6'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (out_hs && last_p2_q) rows_out_d = rows_out_q + 6'd1;

    // Address walks +1 per lane; each new row starts at the previous row base plus stride.
    if (issue) begin
      if (pop) begin
        lane_d     = '0;
        row_base_d = row_base_q + stride_q;
        addr_d     = row_base_q + stride_q;
      end else begin
        lane_d = lane_q + LANE_W'(1);
        addr_d = addr_q + ADDR_OUT'(1);
      end
    end

    if (adv) begin
      vld_p0_d = issue;
      vld_p1_d = vld_p0_q;
      vld_p2_d = vld_p1_q;
    end
    // Stage p0: lane select and multiply.
    if (issue) begin
      prod_p0_d = PROD_W'(lane_val) * PROD_W'(mult_s);
      addr_p0_d = addr_q;  tag_p0_d = tag_mem_q[rd_ptr_q];  last_p0_d = pop;
    end
    // Stage p1: rounding shift.
    if (adv && vld_p0_q) begin
      rnd_p1_d  = round_shift(prod_p0_q, shift_q);
      addr_p1_d = addr_p0_q;  tag_p1_d = tag_p0_q;  last_p1_d = last_p0_q;
    end
    // Stage p2: ReLU, zero point, clamp into the output register.
    if (adv && vld_p1_q) begin
      data_p2_d = relu_zp_sat(rnd_p1_q, relu_q, zp_q);
      addr_p2_d = addr_p1_q;  tag_p2_d = tag_p1_q;  last_p2_d = last_p1_q;
    end

    psum_ready_d = (state_d == S_RUN) && (cnt_d != 2'd2) && (accepted_d < rows_d);
    busy_d       = (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
  end

  // Control state and visible outputs; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;  rows_q <= '0;  accepted_q <= '0;  rows_out_q <= '0;
      mult_q <= '0;  shift_q <= '0;  zp_q <= '0;  relu_q <= 1'b0;  stride_q <= '0;
      addr_q <= '0;  row_base_q <= '0;  lane_q <= '0;
      wr_ptr_q <= 1'b0;  rd_ptr_q <= 1'b0;  cnt_q <= '0;
      vld_p0_q <= 1'b0;  vld_p1_q <= 1'b0;  vld_p2_q <= 1'b0;
      data_p2_q <= '0;  addr_p2_q <= '0;  tag_p2_q <= '0;  last_p2_q <= 1'b0;
      psum_ready_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  rows_q <= rows_d;  accepted_q <= accepted_d;  rows_out_q <= rows_out_d;
      mult_q <= mult_d;  shift_q <= shift_d;  zp_q <= zp_d;  relu_q <= relu_d;  stride_q <= stride_d;
      addr_q <= addr_d;  row_base_q <= row_base_d;  lane_q <= lane_d;
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  cnt_q <= cnt_d;
      vld_p0_q <= vld_p0_d;  vld_p1_q <= vld_p1_d;  vld_p2_q <= vld_p2_d;
      data_p2_q <= data_p2_d;  addr_p2_q <= addr_p2_d;  tag_p2_q <= tag_p2_d;  last_p2_q <= last_p2_d;
      psum_ready_q <= psum_ready_d;  busy_q <= busy_d;  done_q <= done_d;
    end
  end

  // FIFO storage and internal pipeline data; qualified by counters/valids, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;  tag_mem_q <= tag_mem_d;
    prod_p0_q <= prod_p0_d;  addr_p0_q <= addr_p0_d;  tag_p0_q <= tag_p0_d;  last_p0_q <= last_p0_d;
    rnd_p1_q <= rnd_p1_d;  addr_p1_q <= addr_p1_d;  tag_p1_q <= tag_p1_d;  last_p1_q <= last_p1_d;
  end

  assign bus.psum_ready = psum_ready_q;
  assign bus.out_valid  = vld_p2_q;
  assign bus.out_data   = data_p2_q;
  assign bus.out_addr   = addr_p2_q;
  assign bus.out_tag    = tag_p2_q;
  assign bus.out_last   = last_p2_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: doc/psum_drain_quant.md
# psum_drain_quant

Output-side drain for the dense core. Accepts 32-lane × 32-bit partial-sum row vectors from the core's `psum_rows` bus over a valid/ready handshake and buffers up to two vectors. Requantizes each lane to int8 (multiply, rounding shift, ReLU, zero-point, clamp) and streams the result one byte per cycle, with a destination address, toward the AXI write path.

## Interface

Parameters:

- PSUM_BW, 32, partial-sum lane width (signed)
- NUM_COLS, 32, lanes per psum vector
- OUT_BW, 8, output byte width
- ADDR_PSUM, 11, psum row-tag width
- ADDR_OUT, 20, output address width

Ports:

- clk  in  1  single clock; all logic rising-edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches config; honoured only in IDLE
- row_count  in  6  vectors to drain this run (0..32)
- quant_mult  in  16  unsigned requant multiplier
- quant_shift  in  5  right-shift amount (0..31)
- zero_point  in  8  signed output zero point
- relu_en  in  1  clamp negative pre-zp values to 0
- out_base_addr  in  ADDR_OUT  address of row 0, lane 0
- row_stride  in  ADDR_OUT  address increment per row
- psum_valid  in  1  core presents a vector
- psum_ready  out  1  block accepts a vector this cycle
- psum_rows  in  PSUM_BW*NUM_COLS  lane i = bits [32i+31:32i]
- psum_addr  in  ADDR_PSUM  row tag, echoed on out_tag
- out_valid  out  1  byte valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_BW  signed int8 result
- out_addr  out  ADDR_OUT  destination address
- out_tag  out  ADDR_PSUM  psum_addr of the source vector
- out_last  out  1  lane NUM_COLS-1 of a vector
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run

## Operation

- FSM: IDLE → RUN on `start`. RUN → DONE after the handshake of the byte with out_last on row row_count-1. DONE → IDLE unconditionally; `done`=1 only in DONE.
- row_count=0: IDLE → RUN → DONE with no transfers.
- `start` in RUN or DONE is ignored. Config is latched at `start`; later changes have no effect until the next run.
- Buffer: 2-entry vector FIFO.
  - psum_ready = RUN && entries<2 && accepted<row_count.
  - Transfer happens on psum_valid && psum_ready.
  - Simultaneous push and pop in one cycle is legal.
- Lane serializer: reads lanes 0..31 of the head entry, one lane per pipeline advance. Pops the entry after lane 31 enters the pipe.
- Arithmetic, per lane:
  - p = signed(psum) × signed({1'b0, quant_mult}), 49-bit.
  - r = (p + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (arithmetic).
  - if relu_en and r<0 then r=0.
  - v = r + sign-extended zero_point.
  - out = clamp(v, -128, 127).
- Address: running counter. Starts at out_base_addr. +1 per lane. At row end, row base += row_stride; the next row starts at the new base. No multiplier.
- Reset: any cycle with resetn=0 returns FSM to IDLE, empties the FIFO and pipeline, and clears all counters. Reset mid-run drops in-flight data.

## Timing

- Reset values:
  - 0: psum_ready, out_valid, out_data, out_addr, out_tag, out_last, busy, done.
- Pipeline: 3 stages (lane select/multiply, round/shift, relu/zp/clamp into output register).
- Latency: vector accepted at edge t (empty pipe, out_ready=1) → lane 0 on out_valid after edge t+3.
- Throughput: 1 byte/cycle. Consecutive buffered rows flow with no bubble; 32 cycles per row.
- Stall: when out_valid && !out_ready, all stages hold. out_data, out_addr, out_tag and out_last stay stable until the handshake.
- busy rises the edge after `start`. done rises the edge after the final handshake.

## Test plan

- Basic run:
  - Stimulus: row_count=1, mult=1, shift=0, zp=0, relu_en=0, lane i = i, base=0x100.
  - Response: out_data 0..31 on addresses 0x100..0x11F. out_last only on lane 31. done pulses once, one cycle after the last handshake.
- Rounding and clamp, with zp=0:
  - psum=1000, mult=3, shift=4 → 188 → 127.
  - psum=-5, mult=1, shift=1 → -2.
  - psum=-100000, mult=1, shift=0 → -128.
- ReLU and zero point, with relu_en=1, zp=10, mult=1, shift=0:
  - psum=-50 → 10.
  - psum=20 → 30.
  - psum=200 → 127.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,1,0 while the core offers 3 rows continuously.
  - Response: outputs hold stable while stalled. psum_ready=0 while 2 entries are held. All 96 bytes arrive in order with none lost or duplicated.
- Multi-row:
  - Stimulus: row_count=3, base=0x100, row_stride=0x40, tags 5,6,7.
  - Response: rows start at 0x100, 0x140, 0x180 with out_tag 5/6/7. psum_ready stays 0 after the third accept.
- Reset mid-run:
  - Stimulus: resetn=0 for 1 cycle during row 1 lane 10.
  - Response: all outputs 0 on the next edge, FSM in IDLE. A following start with row_count=1 completes correctly with no stale bytes.
